// File: rtl/bus_pkg.sv
// -----------------------------------------------------------------------------
// bus_pkg
// Shared definitions for the serial system bus arbiter:
//   - arb_state_e  : arbiter FSM states (IDLE, GRANT, SEL, BUSY)
//   - NUM_SLAVES   : number of addressable slaves behind the interconnect
//   - SLV_S1..S3   : slave ID encodings carried on the serial select lines
//   - slave_onehot : slave ID -> one-hot enable; unknown IDs decode to zero
// -----------------------------------------------------------------------------
package bus_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      GRANT = 2'd1,
      SEL   = 2'd2,
      BUSY  = 2'd3
   } arb_state_e;

   localparam int NUM_SLAVES = 3;

   localparam logic [31:0] SLV_S1 = 32'd0;
   localparam logic [31:0] SLV_S2 = 32'd1;
   localparam logic [31:0] SLV_S3 = 32'd2;

   // An all-zero result marks an invalid ID; the arbiter relies on that.
   function automatic logic [NUM_SLAVES-1:0] slave_onehot(input logic [31:0] id);
      logic [NUM_SLAVES-1:0] oh;
      case (id)
         SLV_S1:  oh = 3'b001;
         SLV_S2:  oh = 3'b010;
         SLV_S3:  oh = 3'b100;
         default: oh = 3'b000;
      endcase
      return oh;
   endfunction

endpackage

// File: rtl/bus_arbiter_sel_shift_in.sv
// -----------------------------------------------------------------------------
// sel_shift_in
// SLAVE_LEN-bit serial-in shift register, MSB first, used while the arbiter
// collects the owner's slave ID.
// Ports:
//   clk_i     : system clock
//   reset_i   : synchronous, active-high reset
//   clr_i     : synchronous clear (takes precedence over enable)
//   en_i      : shift din_i in at the LSB end
//   din_i     : serial data bit
//   q_next_o  : value the register would hold after shifting din_i in, so the
//               caller can decode the full ID on the cycle of the last bit
// -----------------------------------------------------------------------------
module sel_shift_in #(
   parameter int SLAVE_LEN = 2
) (
   input  logic                 clk_i,
   input  logic                 reset_i,
   input  logic                 clr_i,
   input  logic                 en_i,
   input  logic                 din_i,
   output logic [SLAVE_LEN-1:0] q_next_o
);

   logic [SLAVE_LEN-1:0] sh_q;
   logic [SLAVE_LEN:0]   cat_s;

   // Concatenate and drop the oldest bit; works for any SLAVE_LEN >= 1.
   always_comb begin
      cat_s    = {sh_q, din_i};
      q_next_o = cat_s[SLAVE_LEN-1:0];
   end

   // Shift register state: clear wins over shift.
   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         sh_q <= '0;
      end else if (clr_i) begin
         sh_q <= '0;
      end else if (en_i) begin
         sh_q <= q_next_o;
      end else begin
         sh_q <= sh_q;
      end
   end

endmodule

// File: rtl/bus_arbiter.sv
// -----------------------------------------------------------------------------
// bus_arbiter
// Two-master arbiter and slave-address decoder for the serial system bus.
// Grants the bus to one master, shifts in its serial slave ID, drives the
// one-hot slave enables and master mux select, and holds ownership until
// trans_done or a BUSY timeout.
//
// Build option: define ARB_ROUND_ROBIN_EN for round-robin tie breaking;
// otherwise m1 wins simultaneous requests (fixed priority, no pointer).
//
// Ports:
//   clk, reset                 : clock, synchronous active-high reset
//   m1_request, m2_request     : level bus requests
//   m1_slave_sel, m2_slave_sel : serial slave IDs, MSB first
//   trans_done                 : owner's transaction complete pulse
//   m1_grant, m2_grant         : bus ownership
//   arbiter_busy               : FSM is not IDLE
//   bus_busy                   : slave path routed (BUSY)
//   master_sel                 : 0 = m1 drives the mux, 1 = m2
//   slave_en                   : one-hot slave enable (S1, S2, S3)
//   timeout_err                : one-cycle pulse on forced release
// All outputs are registered.
// -----------------------------------------------------------------------------
module bus_arbiter
   import bus_pkg::*;
#(
   parameter int SLAVE_LEN      = 2,
   parameter int TIMEOUT_CYCLES = 4095
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  m1_request,
   input  logic                  m2_request,
   input  logic                  m1_slave_sel,
   input  logic                  m2_slave_sel,
   input  logic                  trans_done,
   output logic                  m1_grant,
   output logic                  m2_grant,
   output logic                  arbiter_busy,
   output logic                  bus_busy,
   output logic                  master_sel,
   output logic [NUM_SLAVES-1:0] slave_en,
   output logic                  timeout_err
);

   localparam int CNT_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
   localparam int BIT_W = (SLAVE_LEN > 1) ? $clog2(SLAVE_LEN) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
   localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(SLAVE_LEN - 1);

   arb_state_e            state_q;
   logic                  m1_grant_q;
   logic                  m2_grant_q;
   logic                  arbiter_busy_q;
   logic                  bus_busy_q;
   logic                  master_sel_q;   // doubles as the latched owner
   logic [NUM_SLAVES-1:0] slave_en_q;
   logic                  timeout_err_q;
   logic [BIT_W-1:0]      bit_cnt_q;
   logic [CNT_W-1:0]      tmo_cnt_q;

   logic                  any_req_s;
   logic                  pick_m2_s;
   logic                  sel_bit_s;
   logic [SLAVE_LEN-1:0]  id_next_s;
   logic [31:0]           id_ext_s;
   logic [NUM_SLAVES-1:0] slave_dec_s;

   assign any_req_s = m1_request | m2_request;

`ifdef ARB_ROUND_ROBIN_EN
   logic last_m2_q;   // 1 = m2 was served most recently

   // Winner selection: on a tie the master not served last wins.
   always_comb begin
      pick_m2_s = 1'b0;
      if (m1_request && m2_request) begin
         pick_m2_s = ~last_m2_q;
      end else begin
         pick_m2_s = m2_request;
      end
   end

   // Round-robin pointer; reset value makes m1 win the first tie.
   always_ff @(posedge clk) begin
      if (reset) begin
         last_m2_q <= 1'b1;
      end else if ((state_q == IDLE) && any_req_s) begin
         last_m2_q <= pick_m2_s;
      end else begin
         last_m2_q <= last_m2_q;
      end
   end
`else
   // Winner selection: fixed priority, m1 wins every tie.
   always_comb begin
      pick_m2_s = 1'b0;
      if (m1_request) begin
         pick_m2_s = 1'b0;
      end else begin
         pick_m2_s = m2_request;
      end
   end
`endif

   // Owner's serial select line and decode of the ID including the incoming bit.
   always_comb begin
      sel_bit_s = master_sel_q ? m2_slave_sel : m1_slave_sel;
      id_ext_s  = 32'd0;
      id_ext_s[SLAVE_LEN-1:0] = id_next_s;
      slave_dec_s = slave_onehot(id_ext_s);
   end

   sel_shift_in #(
      .SLAVE_LEN (SLAVE_LEN)
   ) u_sel_shift_in (
      .clk_i    (clk),
      .reset_i  (reset),
      .clr_i    (state_q == GRANT),
      .en_i     (state_q == SEL),
      .din_i    (sel_bit_s),
      .q_next_o (id_next_s)
   );

   // Arbiter FSM with registered outputs computed from the next state.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q        <= IDLE;
         m1_grant_q     <= 1'b0;
         m2_grant_q     <= 1'b0;
         arbiter_busy_q <= 1'b0;
         bus_busy_q     <= 1'b0;
         master_sel_q   <= 1'b0;
         slave_en_q     <= 3'b000;
         timeout_err_q  <= 1'b0;
         bit_cnt_q      <= '0;
         tmo_cnt_q      <= '0;
      end else begin
         timeout_err_q <= 1'b0;
         case (state_q)
            IDLE: begin
               if (any_req_s) begin
                  state_q        <= GRANT;
                  master_sel_q   <= pick_m2_s;
                  m1_grant_q     <= ~pick_m2_s;
                  m2_grant_q     <= pick_m2_s;
                  arbiter_busy_q <= 1'b1;
               end else begin
                  state_q <= IDLE;
               end
            end
            GRANT: begin
               state_q   <= SEL;
               bit_cnt_q <= '0;
            end
            SEL: begin
               if (bit_cnt_q == BIT_LAST) begin
                  if (slave_dec_s != 3'b000) begin
                     state_q    <= BUSY;
                     slave_en_q <= slave_dec_s;
                     bus_busy_q <= 1'b1;
                     tmo_cnt_q  <= '0;
                  end else begin
                     // Invalid slave ID: drop ownership without routing.
                     state_q        <= IDLE;
                     m1_grant_q     <= 1'b0;
                     m2_grant_q     <= 1'b0;
                     arbiter_busy_q <= 1'b0;
                  end
               end else begin
                  bit_cnt_q <= bit_cnt_q + BIT_W'(1);
               end
            end
            BUSY: begin
               if (trans_done || (tmo_cnt_q == CNT_LAST)) begin
                  state_q        <= IDLE;
                  m1_grant_q     <= 1'b0;
                  m2_grant_q     <= 1'b0;
                  arbiter_busy_q <= 1'b0;
                  bus_busy_q     <= 1'b0;
                  slave_en_q     <= 3'b000;
                  // A completing transaction on the last cycle is not an error.
                  timeout_err_q  <= ~trans_done;
               end else if (tmo_cnt_q != {CNT_W{1'b1}}) begin
                  tmo_cnt_q <= tmo_cnt_q + CNT_W'(1);
               end else begin
                  tmo_cnt_q <= tmo_cnt_q;
               end
            end
            default: begin
               state_q        <= IDLE;
               m1_grant_q     <= 1'b0;
               m2_grant_q     <= 1'b0;
               arbiter_busy_q <= 1'b0;
               bus_busy_q     <= 1'b0;
               slave_en_q     <= 3'b000;
            end
         endcase
      end
   end

   assign m1_grant     = m1_grant_q;
   assign m2_grant     = m2_grant_q;
   assign arbiter_busy = arbiter_busy_q;
   assign bus_busy     = bus_busy_q;
   assign master_sel   = master_sel_q;
   assign slave_en     = slave_en_q;
   assign timeout_err  = timeout_err_q;

endmodule

// File: tb/tb_bus_arbiter.sv
// -----------------------------------------------------------------------------
// tb_bus_arbiter
// Directed bench for bus_arbiter (SLAVE_LEN = 2, TIMEOUT_CYCLES = 16).
// Outputs are packed as {m1_grant, m2_grant, arbiter_busy, bus_busy,
// master_sel, slave_en[2:0], timeout_err} and compared against hand-built
// expected vectors, sampled 1 ns after each rising edge.
// -----------------------------------------------------------------------------
module tb_bus_arbiter;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       m1_request = 1'b0;
   logic       m2_request = 1'b0;
   logic       m1_slave_sel = 1'b0;
   logic       m2_slave_sel = 1'b0;
   logic       trans_done = 1'b0;
   logic       m1_grant;
   logic       m2_grant;
   logic       arbiter_busy;
   logic       bus_busy;
   logic       master_sel;
   logic [2:0] slave_en;
   logic       timeout_err;
   logic [8:0] obs_s;

   int n_checks = 0;
   int n_fail = 0;

   bus_arbiter #(
      .SLAVE_LEN      (2),
      .TIMEOUT_CYCLES (16)
   ) dut (
      .clk          (clk),
      .reset        (reset),
      .m1_request   (m1_request),
      .m2_request   (m2_request),
      .m1_slave_sel (m1_slave_sel),
      .m2_slave_sel (m2_slave_sel),
      .trans_done   (trans_done),
      .m1_grant     (m1_grant),
      .m2_grant     (m2_grant),
      .arbiter_busy (arbiter_busy),
      .bus_busy     (bus_busy),
      .master_sel   (master_sel),
      .slave_en     (slave_en),
      .timeout_err  (timeout_err)
   );

   // Free-running 10 ns clock.
   always #5 clk = ~clk;

   assign obs_s = {m1_grant, m2_grant, arbiter_busy, bus_busy, master_sel, slave_en, timeout_err};

   // Expected output vector built from individual fields.
   function automatic logic [8:0] ov(input logic g1, input logic g2, input logic ab,
                                     input logic bb, input logic ms, input logic [2:0] se,
                                     input logic te);
      return {g1, g2, ab, bb, ms, se, te};
   endfunction

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic drive_sel(input logic who, input logic b);
      if (who) m2_slave_sel = b;
      else     m1_slave_sel = b;
   endtask

   // Called just after the GRANT edge: GRANT->SEL, then two ID bits MSB first.
   task automatic sel_phase(input logic who, input logic [1:0] id);
      step();
      drive_sel(who, id[1]);
      step();
      drive_sel(who, id[0]);
      step();
   endtask

   task automatic pulse_done();
      trans_done = 1'b1;
      step();
      trans_done = 1'b0;
   endtask

   task automatic reset_dut();
      reset = 1'b1;
      m1_request = 1'b0;
      m2_request = 1'b0;
      step();
      check("reset_state", 32'(obs_s), 32'(ov(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'b000, 1'b0)));
      reset = 1'b0;
   endtask

   initial begin
      logic w;

      // Reset state
      #1;
      reset_dut();

      // m1 alone, ID 2 (bits 1,0) -> S3
      m1_request = 1'b1;
      step();
      check("m1_grant", 32'(obs_s), 32'(ov(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 3'b000, 1'b0)));
      sel_phase(1'b0, 2'b10);
      m1_request = 1'b0;
      check("m1_busy_s3", 32'(obs_s), 32'(ov(1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 3'b100, 1'b0)));
      pulse_done();
      check("m1_done", 32'(obs_s), 32'(ov(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'b000, 1'b0)));
      trans_done = 1'b1;   // outside BUSY: must be ignored
      step();
      trans_done = 1'b0;
      check("done_idle", 32'(obs_s), 32'(ov(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'b000, 1'b0)));

      // Simultaneous requests, ID 0 from both masters, four transactions
      reset_dut();
      m1_request = 1'b1;
      m2_request = 1'b1;
      m1_slave_sel = 1'b0;
      m2_slave_sel = 1'b0;
      for (int i = 0; i < 4; i++) begin
`ifdef ARB_ROUND_ROBIN_EN
         w = (i % 2 == 1) ? 1'b1 : 1'b0;
`else
         w = 1'b0;
`endif
         step();
         check("tie_grant", 32'(obs_s), 32'(ov(~w, w, 1'b1, 1'b0, w, 3'b000, 1'b0)));
         sel_phase(w, 2'b00);
         check("tie_busy", 32'(obs_s), 32'(ov(~w, w, 1'b1, 1'b1, w, 3'b001, 1'b0)));
         pulse_done();
         check("tie_done", 32'(obs_s), 32'(ov(1'b0, 1'b0, 1'b0, 1'b0, w, 3'b000, 1'b0)));
      end
      m1_request = 1'b0;
      m2_request = 1'b0;
      step();

      // m2 owns the bus, m1 request ignored until m2 releases
      reset_dut();
      m2_request = 1'b1;
      step();
      check("m2_grant", 32'(obs_s), 32'(ov(1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 3'b000, 1'b0)));
      sel_phase(1'b1, 2'b01);
      check("m2_busy_s2", 32'(obs_s), 32'(ov(1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 3'b010, 1'b0)));
      m1_request = 1'b1;
      for (int i = 0; i < 3; i++) begin
         step();
         check("m1_blocked", 32'(obs_s), 32'(ov(1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 3'b010, 1'b0)));
      end
      m2_request = 1'b0;
      pulse_done();
      check("idle_gap", 32'(obs_s), 32'(ov(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 3'b000, 1'b0)));
      step();
      check("m1_after_gap", 32'(obs_s), 32'(ov(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 3'b000, 1'b0)));

      // Invalid ID 3 from m1; its request drop mid-transaction is ignored
      m1_request = 1'b0;
      step();
      check("owner_drop", 32'(obs_s), 32'(ov(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 3'b000, 1'b0)));
      m1_slave_sel = 1'b1;
      step();
      check("inv_sel", 32'(obs_s), 32'(ov(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 3'b000, 1'b0)));
      m1_slave_sel = 1'b1;
      step();
      check("inv_release", 32'(obs_s), 32'(ov(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'b000, 1'b0)));
      step();
      check("inv_no_err", 32'(obs_s), 32'(ov(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'b000, 1'b0)));

      // Timeout: ID 1, no trans_done, release after 16 BUSY cycles
      m1_request = 1'b1;
      step();
      m1_request = 1'b0;
      sel_phase(1'b0, 2'b01);
      check("tmo_busy", 32'(obs_s), 32'(ov(1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 3'b010, 1'b0)));
      for (int i = 0; i < 15; i++) step();
      check("tmo_last_busy", 32'(obs_s), 32'(ov(1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 3'b010, 1'b0)));
      step();
      check("tmo_release", 32'(obs_s), 32'(ov(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'b000, 1'b1)));
      step();
      check("tmo_pulse_end", 32'(obs_s), 32'(ov(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'b000, 1'b0)));

      // Reset mid-SEL (owner m2)
      m2_request = 1'b1;
      step();
      step();
      m2_slave_sel = 1'b1;
      step();
      reset_dut();

      // Reset mid-BUSY (owner m1), then a tie must go to m1
      m1_request = 1'b1;
      step();
      sel_phase(1'b0, 2'b00);
      check("pre_reset_busy", 32'(obs_s), 32'(ov(1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 3'b001, 1'b0)));
      reset_dut();
      m1_request = 1'b1;
      m2_request = 1'b1;
      step();
      check("tie_after_reset", 32'(obs_s), 32'(ov(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 3'b000, 1'b0)));
      m1_request = 1'b0;
      m2_request = 1'b0;

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
